// File: rtl/masked_xor_accumulator.sv
// masked_xor_accumulator: share-wise XOR accumulation of NUM_WORDS masked operands per job.
// Define MASKED_XOR_REFRESH_EN to add in_random and remask the result on entry to DONE.
module masked_xor_accumulator #(
   parameter int NUM_SHARES = 2,
   parameter int WIDTH      = 8,
   parameter int NUM_WORDS  = 4
) (
   input  logic                          in_clock,
   input  logic                          in_reset_n,
   input  logic                          in_start,
   input  logic [NUM_SHARES*WIDTH-1:0]   in_data,
   input  logic                          in_valid,
   output logic                          out_ready,
   output logic [NUM_SHARES*WIDTH-1:0]   out_result,
   output logic                          out_valid,
   input  logic                          in_ready,
`ifdef MASKED_XOR_REFRESH_EN
   input  logic [(NUM_SHARES-1)*WIDTH-1:0] in_random,
`endif
   output logic                          out_busy
);
   localparam int DW = NUM_SHARES*WIDTH;
   localparam int CW = $clog2(NUM_WORDS)+1;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state, state_nx;
   logic [DW-1:0] acc, acc_nx, mask;
   logic [CW-1:0] cnt, cnt_nx;
   always_comb begin
      mask = '0;
`ifdef MASKED_XOR_REFRESH_EN
      // last share absorbs every random word so the unmasked value is preserved
      for (int i = 0; i < NUM_SHARES-1; i++) begin
         mask[i*WIDTH +: WIDTH] = in_random[i*WIDTH +: WIDTH];
         mask[(NUM_SHARES-1)*WIDTH +: WIDTH] = mask[(NUM_SHARES-1)*WIDTH +: WIDTH] ^ in_random[i*WIDTH +: WIDTH];
      end
`endif
   end
   always_comb begin
      state_nx = state;
      acc_nx = acc;
      cnt_nx = cnt;
      case (state)
         IDLE: if (in_start) begin
            state_nx = ACCUM;
            acc_nx = '0;
            cnt_nx = '0;
         end
         ACCUM: if (in_valid) begin
            cnt_nx = cnt + CW'(1);
            acc_nx = acc ^ in_data;
            if (cnt == CW'(NUM_WORDS-1)) begin
               state_nx = DONE;
               acc_nx = acc ^ in_data ^ mask;
            end
         end
         DONE: state_nx = in_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge in_clock or negedge in_reset_n)
      if (!in_reset_n) begin
         state <= IDLE;
         acc <= '0;
         cnt <= '0;
      end else begin
         state <= state_nx;
         acc <= acc_nx;
         cnt <= cnt_nx;
      end
   assign out_ready = state == ACCUM;
   assign out_valid = state == DONE;
   assign out_busy = state != IDLE;
   assign out_result = acc;
endmodule

// File: tb/tb_masked_xor_accumulator.sv
// tb_masked_xor_accumulator: directed jobs with a result scoreboard checked by a decoupled monitor.
module tb_masked_xor_accumulator;
   logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_ready = 1;
   logic [15:0] in_data = '0;
   logic out_ready, out_valid, out_busy;
   logic [15:0] out_result;
   int checks = 0, errors = 0;
   logic [15:0] q[$];
   logic [15:0] cur = '0;
   logic prev_v = 0;
`ifdef MASKED_XOR_REFRESH_EN
   localparam logic [15:0] RMASK = 16'hA5A5;
   logic [7:0] rnd = 8'hA5;
`else
   localparam logic [15:0] RMASK = 16'h0000;
`endif
   masked_xor_accumulator #(.NUM_SHARES(2), .WIDTH(8), .NUM_WORDS(4)) dut (
      .in_clock(clk), .in_reset_n(rst_n), .in_start(start), .in_data(in_data),
      .in_valid(in_valid), .out_ready(out_ready), .out_result(out_result),
      .out_valid(out_valid), .in_ready(in_ready),
`ifdef MASKED_XOR_REFRESH_EN
      .in_random(rnd),
`endif
      .out_busy(out_busy));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", n, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (out_valid) begin
         if (!prev_v) begin
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result actual %h expected none", out_result);
            end else cur = q.pop_front();
         end
         chk("result", out_result, cur);
      end
      prev_v = out_valid;
   end
   task automatic job(input logic [15:0] ops[4], input int stall, input logic [15:0] exp);
      q.push_back(exp ^ RMASK);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      chk("busy_accum", {15'd0, out_busy}, 16'd1);
      for (int k = 0; k < 4; k++) begin
         repeat (stall) begin
            chk("ready_stall", {15'd0, out_ready}, 16'd1);
            @(posedge clk); #1;
         end
         chk("ready", {15'd0, out_ready}, 16'd1);
         in_data = ops[k];
         in_valid = 1;
         @(posedge clk); #1;
         in_valid = 0;
      end
      chk("valid_latency", {15'd0, out_valid}, 16'd1);
   endtask
   task automatic wait_idle();
      int t = 0;
      while (out_busy && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("idle_timeout", {15'd0, out_busy}, 16'd0);
   endtask
   logic [15:0] ja[4] = '{16'h3412, 16'h7856, 16'hBC9A, 16'hF0DE};
   logic [15:0] jc[4] = '{16'h2211, 16'h0201, 16'h4000, 16'h0080};
   logic [15:0] jr[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
   initial begin
      #2;
      chk("rst_busy", {15'd0, out_busy}, 16'd0);
      chk("rst_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_ready", {15'd0, out_ready}, 16'd0);
      chk("rst_result", out_result, 16'h0000);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      job(ja, 0, 16'h0000);
      wait_idle();
      job(jc, 0, 16'h6090);
      wait_idle();
      job(ja, 3, 16'h0000);
      wait_idle();
      job(jc, 1, 16'h6090);
      in_ready = 0;
      for (int c = 0; c < 5; c++) begin
         chk("hold_valid", {15'd0, out_valid}, 16'd1);
         start = (c == 2);
         @(posedge clk); #1;
      end
      start = 0;
      chk("hold_valid_end", {15'd0, out_valid}, 16'd1);
      in_ready = 1;
      @(posedge clk); #1;
      chk("handoff_idle", {15'd0, out_busy}, 16'd0);
      @(posedge clk); #1;
      chk("start_ignored", {15'd0, out_busy}, 16'd0);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      for (int k = 0; k < 2; k++) begin
         in_data = k == 0 ? 16'h55AA : 16'hF00F;
         in_valid = 1;
         @(posedge clk); #1;
      end
      in_valid = 0;
      rst_n = 0;
      #1;
      chk("mid_rst_busy", {15'd0, out_busy}, 16'd0);
      chk("mid_rst_ready", {15'd0, out_ready}, 16'd0);
      chk("mid_rst_result", out_result, 16'h0000);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      job(jr, 0, 16'h0000);
      wait_idle();
      repeat (4) @(posedge clk);
      #1;
      chk("queue_empty", 16'(q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
